// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : elevator_pkg
//  Purpose : Shared floor codes, floor-code width, car state encoding and a
//            floor-stepping helper for the elevator car.
//  Revision: 1.0 - initial release
// ============================================================================
package elevator_pkg;

  localparam int FLOOR_W    = 4;
  localparam int NUM_FLOORS = 3;

  localparam logic [FLOOR_W-1:0] FLOOR_G = 4'd0;
  localparam logic [FLOOR_W-1:0] FLOOR_1 = 4'd1;
  localparam logic [FLOOR_W-1:0] FLOOR_2 = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2,
    ST_HALT = 2'd3
  } car_state_e;

  // One floor up or down from the current floor. Targets are range-checked
  // at acceptance, so the car never steps past ground or the top floor.
  function automatic logic [FLOOR_W-1:0] next_floor(
    input logic [FLOOR_W-1:0] cur,
    input logic               up
  );
    next_floor = up ? (cur + 4'd1) : (cur - 4'd1);
  endfunction

endpackage : elevator_pkg
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// ============================================================================
//  Module  : dwell_timer
//  Purpose : 8-bit dwell counter. load clears the count; while enable is high
//            the count advances and wraps to zero on the cycle done is high.
//            done flags the last cycle of a LIMIT-cycle interval.
//  Ports   : clk    - clock
//            reset  - asynchronous active-low reset
//            load   - clear count to 0 (has priority over enable)
//            enable - advance the count
//            limit  - interval length in cycles (>= 1)
//            done   - count == limit-1
//  Revision: 1.0 - initial release
// ============================================================================
module dwell_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       done
);

  logic [7:0] r_count;

  assign done = (r_count == (limit - 8'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 8'd0;
    end else if (load) begin
      r_count <= 8'd0;
    end else if (enable) begin
      r_count <= done ? 8'd0 : (r_count + 8'd1);
    end
  end

endmodule : dwell_timer
`default_nettype wire

// File: rtl/elevator_car.sv
`default_nettype none
// ============================================================================
//  Module  : elevator_car
//  Purpose : Three-floor elevator car controller. Accepts one request at a
//            time in IDLE, travels floor by floor, opens the door on arrival
//            and latches an emergency halt until reset.
//  Ports   : clk        - clock
//            reset      - asynchronous active-low reset
//            req_floor  - requested floor code (0..2 legal)
//            req_valid  - request present
//            req_ready  - car can accept a request (combinational)
//            emerg      - emergency stop
//            cur_floor  - current floor code
//            motor_up   - moving up
//            motor_dn   - moving down
//            door_open  - door open
//            arrived    - one-cycle pulse on reaching the target floor
//            bad_req    - one-cycle pulse on an accepted illegal floor code
//            halted     - emergency latched
//  Revision: 1.0 - initial release
// ============================================================================
module elevator_car
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOOR_W-1:0] req_floor,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               emerg,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               motor_up,
  output logic               motor_dn,
  output logic               door_open,
  output logic               arrived,
  output logic               bad_req,
  output logic               halted
);

  localparam logic [1:0] c_IDLE = ST_IDLE;
  localparam logic [1:0] c_MOVE = ST_MOVE;
  localparam logic [1:0] c_DOOR = ST_DOOR;
  localparam logic [1:0] c_HALT = ST_HALT;

  localparam logic [7:0] c_TRAVEL_LIMIT = 8'(TRAVEL_CYCLES);
  localparam logic [7:0] c_DOOR_LIMIT   = 8'(DOOR_CYCLES);

  logic [1:0]         r_state;
  logic [FLOOR_W-1:0] r_cur_floor;
  logic [FLOOR_W-1:0] r_target;
  logic               r_motor_up;
  logic               r_motor_dn;
  logic               r_door_open;
  logic               r_arrived;
  logic               r_bad_req;
  logic               r_halted;

  logic               w_accept;
  logic               w_bad_floor;
  logic               w_same_floor;
  logic               w_start_move;
  logic               w_travel_done;
  logic               w_door_done;
  logic [FLOOR_W-1:0] w_step_floor;
  logic               w_reach_target;
  logic               w_enter_door;

  assign req_ready = (r_state == c_IDLE) && !emerg;

  // emerg is already excluded by req_ready, so an emergency always wins
  // over a simultaneous request.
  assign w_accept     = req_valid && req_ready;
  assign w_bad_floor  = (req_floor > FLOOR_2);
  assign w_same_floor = (req_floor == r_cur_floor);
  assign w_start_move = w_accept && !w_bad_floor && !w_same_floor;

  // The registered motor_up doubles as the latched travel direction.
  assign w_step_floor   = next_floor(r_cur_floor, r_motor_up);
  assign w_reach_target = (r_state == c_MOVE) && !emerg && w_travel_done &&
                          (w_step_floor == r_target);
  assign w_enter_door   = w_reach_target ||
                          (w_accept && !w_bad_floor && w_same_floor);

  dwell_timer u_travel_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (w_start_move),
    .enable ((r_state == c_MOVE) && !emerg),
    .limit  (c_TRAVEL_LIMIT),
    .done   (w_travel_done)
  );

  dwell_timer u_door_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (w_enter_door),
    .enable ((r_state == c_DOOR) && !emerg),
    .limit  (c_DOOR_LIMIT),
    .done   (w_door_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= c_IDLE;
      r_cur_floor <= FLOOR_G;
      r_target    <= FLOOR_G;
      r_motor_up  <= 1'b0;
      r_motor_dn  <= 1'b0;
      r_door_open <= 1'b0;
      r_arrived   <= 1'b0;
      r_bad_req   <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_arrived <= 1'b0;
      r_bad_req <= 1'b0;
      if (emerg) begin
        // cur_floor and the travel count simply hold from here on.
        r_state     <= c_HALT;
        r_motor_up  <= 1'b0;
        r_motor_dn  <= 1'b0;
        r_door_open <= 1'b0;
        r_halted    <= 1'b1;
      end else begin
        case (r_state)
          c_IDLE: begin
            if (w_accept) begin
              if (w_bad_floor) begin
                r_bad_req <= 1'b1;
              end else if (w_same_floor) begin
                r_state     <= c_DOOR;
                r_door_open <= 1'b1;
                r_arrived   <= 1'b1;
              end else begin
                r_state    <= c_MOVE;
                r_target   <= req_floor;
                r_motor_up <= (req_floor > r_cur_floor);
                r_motor_dn <= (req_floor < r_cur_floor);
              end
            end
          end
          c_MOVE: begin
            if (w_travel_done) begin
              r_cur_floor <= w_step_floor;
              if (w_reach_target) begin
                r_state     <= c_DOOR;
                r_motor_up  <= 1'b0;
                r_motor_dn  <= 1'b0;
                r_door_open <= 1'b1;
                r_arrived   <= 1'b1;
              end
            end
          end
          c_DOOR: begin
            if (w_door_done) begin
              r_state     <= c_IDLE;
              r_door_open <= 1'b0;
            end
          end
          default: begin
            // HALT is sticky until reset.
            r_state <= c_HALT;
          end
        endcase
      end
    end
  end

  assign cur_floor = r_cur_floor;
  assign motor_up  = r_motor_up;
  assign motor_dn  = r_motor_dn;
  assign door_open = r_door_open;
  assign arrived   = r_arrived;
  assign bad_req   = r_bad_req;
  assign halted    = r_halted;

endmodule : elevator_car
`default_nettype wire

// File: tb/tb_elevator_car.sv
`default_nettype none
// ============================================================================
//  Module  : tb_elevator_car
//  Purpose : Directed self-checking bench for elevator_car with
//            TRAVEL_CYCLES=8 and DOOR_CYCLES=4.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_elevator_car;

  logic       clk;
  logic       reset;
  logic [3:0] req_floor;
  logic       req_valid;
  logic       req_ready;
  logic       emerg;
  logic [3:0] cur_floor;
  logic       motor_up;
  logic       motor_dn;
  logic       door_open;
  logic       arrived;
  logic       bad_req;
  logic       halted;

  int checks = 0;
  int errors = 0;

  elevator_car #(
    .TRAVEL_CYCLES (8),
    .DOOR_CYCLES   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_floor (req_floor),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .emerg     (emerg),
    .cur_floor (cur_floor),
    .motor_up  (motor_up),
    .motor_dn  (motor_dn),
    .door_open (door_open),
    .arrived   (arrived),
    .bad_req   (bad_req),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_floor"},  {4'd0, cur_floor}, 8'd0);
    chk({tag, "_up"},     {7'd0, motor_up},  8'd0);
    chk({tag, "_dn"},     {7'd0, motor_dn},  8'd0);
    chk({tag, "_door"},   {7'd0, door_open}, 8'd0);
    chk({tag, "_arr"},    {7'd0, arrived},   8'd0);
    chk({tag, "_bad"},    {7'd0, bad_req},   8'd0);
    chk({tag, "_halted"}, {7'd0, halted},    8'd0);
  endtask

  int n_up;
  int n_dn;

  initial begin
    reset     = 1'b0;
    req_floor = 4'd0;
    req_valid = 1'b0;
    emerg     = 1'b0;
    #1;
    chk_reset_vals("por");
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("ready_after_reset", {7'd0, req_ready}, 8'd1);

    // ---- trip 0 -> 2 ----
    req_floor = 4'd2; req_valid = 1'b1;
    tick(1);                       // edge 0
    req_valid = 1'b0;
    chk("t1_up_e0",    {7'd0, motor_up}, 8'd1);
    chk("t1_dn_e0",    {7'd0, motor_dn}, 8'd0);
    chk("t1_ready_e0", {7'd0, req_ready}, 8'd0);
    tick(7);                       // edge 7
    chk("t1_floor_e7", {4'd0, cur_floor}, 8'd0);
    tick(1);                       // edge 8
    chk("t1_floor_e8", {4'd0, cur_floor}, 8'd1);
    chk("t1_up_e8",    {7'd0, motor_up}, 8'd1);
    tick(7);                       // edge 15
    chk("t1_floor_e15", {4'd0, cur_floor}, 8'd1);
    chk("t1_door_e15",  {7'd0, door_open}, 8'd0);
    tick(1);                       // edge 16
    chk("t1_floor_e16", {4'd0, cur_floor}, 8'd2);
    chk("t1_arr_e16",   {7'd0, arrived},   8'd1);
    chk("t1_door_e16",  {7'd0, door_open}, 8'd1);
    chk("t1_up_e16",    {7'd0, motor_up},  8'd0);
    tick(1);                       // edge 17
    chk("t1_arr_e17",   {7'd0, arrived},   8'd0);
    tick(2);                       // edge 19
    chk("t1_door_e19",  {7'd0, door_open}, 8'd1);
    chk("t1_ready_e19", {7'd0, req_ready}, 8'd0);
    tick(1);                       // edge 20
    chk("t1_door_e20",  {7'd0, door_open}, 8'd0);
    chk("t1_ready_e20", {7'd0, req_ready}, 8'd1);

    // ---- trip 2 -> 0 ----
    req_floor = 4'd0; req_valid = 1'b1;
    tick(1);
    req_valid = 1'b0;
    n_up = 0; n_dn = 0;
    for (int i = 0; i < 16; i++) begin
      n_up += int'(motor_up);
      n_dn += int'(motor_dn);
      tick(1);
    end
    chk("t2_dn_cycles", 8'(n_dn), 8'd16);
    chk("t2_up_cycles", 8'(n_up), 8'd0);
    chk("t2_floor",     {4'd0, cur_floor}, 8'd0);
    chk("t2_arr",       {7'd0, arrived},   8'd1);
    chk("t2_dn_off",    {7'd0, motor_dn},  8'd0);
    tick(4);
    chk("t2_ready",     {7'd0, req_ready}, 8'd1);

    // ---- same-floor request ----
    req_floor = 4'd0; req_valid = 1'b1;
    tick(1);
    req_valid = 1'b0;
    chk("t3_arr",  {7'd0, arrived},   8'd1);
    chk("t3_door", {7'd0, door_open}, 8'd1);
    chk("t3_mot",  {6'd0, motor_up, motor_dn}, 8'd0);
    tick(1);
    chk("t3_arr2", {7'd0, arrived},   8'd0);
    tick(3);
    chk("t3_door_end", {7'd0, door_open}, 8'd0);
    chk("t3_ready",    {7'd0, req_ready}, 8'd1);

    // ---- illegal floor codes ----
    req_floor = 4'hF; req_valid = 1'b1;
    tick(1);
    req_valid = 1'b0;
    chk("t4_bad_f",   {7'd0, bad_req},   8'd1);
    chk("t4_idle_f",  {7'd0, req_ready}, 8'd1);
    chk("t4_floor_f", {4'd0, cur_floor}, 8'd0);
    tick(1);
    chk("t4_bad_clr", {7'd0, bad_req},   8'd0);
    req_floor = 4'd3; req_valid = 1'b1;
    tick(1);
    req_valid = 1'b0;
    chk("t4_bad_3",   {7'd0, bad_req},   8'd1);
    chk("t4_mot_3",   {6'd0, motor_up, motor_dn}, 8'd0);

    // ---- emergency at edge 5 of a 0 -> 2 trip ----
    req_floor = 4'd2; req_valid = 1'b1;
    tick(1);                       // edge 0
    req_floor = 4'd1;              // ignored while moving
    tick(4);                       // edge 4
    chk("t5_up_e4",    {7'd0, motor_up}, 8'd1);
    emerg = 1'b1;
    #1;
    chk("t5_ready_em", {7'd0, req_ready}, 8'd0);
    tick(1);                       // edge 5
    emerg = 1'b0;
    chk("t5_halted",  {7'd0, halted},    8'd1);
    chk("t5_mot",     {6'd0, motor_up, motor_dn}, 8'd0);
    chk("t5_floor",   {4'd0, cur_floor}, 8'd0);
    chk("t5_ready",   {7'd0, req_ready}, 8'd0);
    tick(20);
    chk("t5_halt_sticky", {7'd0, halted},    8'd1);
    chk("t5_floor_held",  {4'd0, cur_floor}, 8'd0);
    chk("t5_mot_held",    {6'd0, motor_up, motor_dn}, 8'd0);
    req_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("t5_rst");
    #1;
    reset = 1'b1;
    tick(1);
    chk("t5_ready_rst", {7'd0, req_ready}, 8'd1);

    // ---- emerg and request on the same edge ----
    req_floor = 4'd1; req_valid = 1'b1; emerg = 1'b1;
    #1;
    chk("t6_ready", {7'd0, req_ready}, 8'd0);
    tick(1);
    req_valid = 1'b0; emerg = 1'b0;
    chk("t6_halted", {7'd0, halted},   8'd1);
    chk("t6_up",     {7'd0, motor_up}, 8'd0);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    tick(1);

    // ---- reset mid-MOVE ----
    req_floor = 4'd2; req_valid = 1'b1;
    tick(1);
    req_valid = 1'b0;
    tick(10);
    chk("t7_floor_mid", {4'd0, cur_floor}, 8'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("t7_move_rst");
    #1;
    reset = 1'b1;
    tick(1);

    // ---- reset mid-DOOR ----
    req_floor = 4'd0; req_valid = 1'b1;
    tick(1);
    req_valid = 1'b0;
    tick(1);
    chk("t8_door_mid", {7'd0, door_open}, 8'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("t8_door_rst");
    #1;
    reset = 1'b1;
    tick(1);
    chk("t8_ready", {7'd0, req_ready}, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_elevator_car
`default_nettype wire
